tb_rstgen: RTL

//  Testbench reset sequencer driven by the tb clock generator's clk output.
//  - Asserts reset to the DUT asynchronously, releases it synchronously after a programmable hold.
//  - Supports mid-sim re-reset requests.
//  - Provides a post-reset cycle counter and an optional watchdog timeout.

---
 rtl/tb_utils_pkg.sv | 11 +
 rtl/tb_rst_sync.sv | 19 +
 rtl/tb_rstgen.sv | 119 +++++++++++
 3 files changed

// File: rtl/tb_utils_pkg.sv
// Shared types and sizing helpers for the bench reset sequencer.
package tb_utils_pkg;

  typedef enum logic [1:0] {RG_ASSERT, RG_HOLD, RG_RUN} rstgen_state_e;

  // Width needed to count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tb_rst_sync.sv
// Async-assert / sync-deassert release chain; rel_sync rises SYNC_STAGES edges after reset drops.
module tb_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic rel_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_chain <= '0;
    else       r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign rel_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/tb_rstgen.sv
// Bench reset sequencer: async assert, synchronized release, hold, re-reset, RUN cycle counter.
// Optional watchdog enabled by defining TB_RSTGEN_WDOG_EN.
module tb_rstgen
  import tb_utils_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_req,
  output logic             rst_o,
  output logic             rst_n_o,
  output logic             busy,
  output logic             ready,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             timeout
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "tb_rstgen: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $fatal(1, "tb_rstgen: HOLD_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $fatal(1, "tb_rstgen: TIMEOUT_CYCLES must be >= 1");
  end

  logic             w_rel;
  rstgen_state_e    r_state, w_state;
  logic [HW-1:0]    r_hold;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic             r_rst, r_ready;
`ifdef TB_RSTGEN_WDOG_EN
  localparam bit WD_REACHABLE = ($clog2(TIMEOUT_CYCLES + 1) <= CNT_W);
  logic             r_timeout;
`endif

  tb_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .rel_sync (w_rel)
  );

  // The sync chain's last flop doubles as the ASSERT->HOLD transition, so HOLD is
  // in effect from the edge the synchronizer output rises (hold_cnt still 0).
  assign w_state   = (r_state == RG_ASSERT && w_rel) ? RG_HOLD : r_state;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RG_ASSERT;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_rst   <= 1'b1;
      r_ready <= 1'b0;
`ifdef TB_RSTGEN_WDOG_EN
      r_timeout <= 1'b0;
`endif
    end else if ($isunknown({reset, sw_req})) begin
      $error("tb_rstgen: X on reset or sw_req");
    end else begin
      r_ready <= 1'b0;
      case (w_state)
        RG_HOLD: begin
          r_state <= RG_HOLD;
          if (sw_req) begin
            r_hold <= '0;
          end else if (r_hold == HOLD_LAST) begin
            r_state <= RG_RUN;
            r_hold  <= '0;
            r_rst   <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        RG_RUN: begin
          if (sw_req) begin
            r_state <= RG_HOLD;
            r_hold  <= '0;
            r_cnt   <= '0;
            r_rst   <= 1'b1;
`ifdef TB_RSTGEN_WDOG_EN
            r_timeout <= 1'b0;
`endif
          end else begin
            r_cnt <= w_cnt_inc;
`ifdef TB_RSTGEN_WDOG_EN
            if (WD_REACHABLE && !r_timeout && w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
              r_timeout <= 1'b1;
              $error("tb_rstgen: watchdog timeout at %0d", w_cnt_inc);
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign rst_o     = r_rst;
  assign rst_n_o   = ~r_rst;
  assign busy      = r_rst;
  assign ready     = r_ready;
  assign cycle_cnt = r_cnt;
`ifdef TB_RSTGEN_WDOG_EN
  assign timeout   = r_timeout;
`else
  assign timeout   = 1'b0;
`endif

endmodule
